// File: rtl/seg7_scan_ctrl_if.sv
// Write-request bus shared by the two display-register requesters (A = CPU, B = debug).
// Requesters drive req/addr/wdata and wait for their one-cycle ack.
interface seg7_scan_ctrl_if;
    logic        req_a;
    logic [1:0]  addr_a;
    logic [31:0] wdata_a;
    logic        ack_a;
    logic        req_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic        ack_b;

    modport master (
        output req_a, addr_a, wdata_a, req_b, addr_b, wdata_b,
        input  ack_a, ack_b
    );

    modport slave (
        input  req_a, addr_a, wdata_a, req_b, addr_b, wdata_b,
        output ack_a, ack_b
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit seven-segment display controller: free-running scan/blink counters plus
// display registers written by two requesters through a round-robin req/ack arbiter.
module seg7_scan_ctrl #(
    parameter int unsigned DIV_W   = 18,
    parameter int unsigned BLINK_W = 25
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_ctrl_if.slave   bus,
    output logic [2:0]        Scan,
    output logic              flash,
    output logic [31:0]       Hexs,
    output logic [7:0]        point,
    output logic [7:0]        LES
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK_A = 2'd1,
        ACK_B = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                rr_b;
    logic                rr_b_nxt;
    logic                wr_en;
    logic [1:0]          wr_addr;
    logic [31:0]         wr_data;
    logic [DIV_W-1:0]    scan_cnt;
    logic [BLINK_W-1:0]  blink_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            blink_cnt <= '0;
        end else begin
            scan_cnt  <= scan_cnt + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign Scan  = scan_cnt[DIV_W-1 -: 3];
    assign flash = blink_cnt[BLINK_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rr_b  <= 1'b0;
        end else begin
            state <= state_nxt;
            rr_b  <= rr_b_nxt;
        end
    end

    // rr_b names the requester that wins the next tie; only a tie moves it to the loser.
    always_comb begin
        state_nxt = state;
        rr_b_nxt  = rr_b;
        wr_en     = 1'b0;
        wr_addr   = bus.addr_a;
        wr_data   = bus.wdata_a;
        case (state)
            IDLE: begin
                if (bus.req_a && (!bus.req_b || !rr_b)) begin
                    wr_en     = 1'b1;
                    state_nxt = ACK_A;
                    if (bus.req_b) rr_b_nxt = 1'b1;
                end else if (bus.req_b) begin
                    wr_en     = 1'b1;
                    wr_addr   = bus.addr_b;
                    wr_data   = bus.wdata_b;
                    state_nxt = ACK_B;
                    if (bus.req_a) rr_b_nxt = 1'b0;
                end
            end
            ACK_A:   state_nxt = IDLE;
            ACK_B:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Hexs  <= '0;
            point <= '0;
            LES   <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                2'd0:    Hexs  <= wr_data;
                2'd1:    point <= wr_data[7:0];
                2'd2:    LES   <= wr_data[7:0];
                default: ;
            endcase
        end
    end

    // Acks come straight from the state register, so reset clears them asynchronously.
    assign bus.ack_a = (state == ACK_A);
    assign bus.ack_b = (state == ACK_B);

endmodule
